// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core with valid/ready handshakes, CTR mode and
// on-the-fly key expansion; ROUNDS_PER_CYCLE rounds are unrolled per clock.
module aes128_iter_core #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned CTR_W            = 32
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [127:0] key,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] iv,
    input  logic         iv_load,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned NR    = 10;
    localparam int unsigned CNT_W = 4;
    localparam logic [127:0] LOW_MASK = {128{1'b1}} >> (128 - CTR_W);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end
    if (CTR_W < 8 || CTR_W > 128) begin : g_bad_ctr_w
        $error("aes128_iter_core: CTR_W must be in 8..128");
    end

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [31:0]  col;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(s[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[c*4+r] = sb[((c + r) % 4)*4 + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            col = {sr[c*4], sr[c*4+1], sr[c*4+2], sr[c*4+3]};
            o[127-32*c -: 32] = last ? col : mix_col(col);
        end
        return o ^ rk;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rn);
        logic [7:0] rc;
        case (rn)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t             r_fsm;
    logic [127:0]       r_state;
    logic [127:0]       r_rkey;
    logic [127:0]       r_data;
    logic               r_mode;
    logic [127:0]       r_counter;
    logic [CNT_W-1:0]   r_round_cnt;
    logic [127:0]       r_out_data;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_in_ready;

    logic [127:0] w_ctr_base;
    logic [127:0] w_ctr_next;
    logic [127:0] w_st  [ROUNDS_PER_CYCLE+1];
    logic [127:0] w_key [ROUNDS_PER_CYCLE+1];

    // Same-edge iv_load takes priority; only the low CTR_W bits count, no carry out.
    assign w_ctr_base = iv_load ? iv : r_counter;
    assign w_ctr_next = (w_ctr_base & ~LOW_MASK) | ((w_ctr_base + 128'd1) & LOW_MASK);

    assign w_st[0]  = r_state;
    assign w_key[0] = r_rkey;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [CNT_W-1:0] w_rn;
        assign w_rn       = r_round_cnt + CNT_W'(j + 1);
        assign w_key[j+1] = next_key(w_key[j], rcon(w_rn));
        assign w_st[j+1]  = aes_round(w_st[j], w_key[j+1], w_rn == CNT_W'(NR));
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_rkey      <= '0;
            r_data      <= '0;
            r_mode      <= 1'b0;
            r_counter   <= '0;
            r_round_cnt <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_mode      <= mode;
                        r_data      <= in_data;
                        r_rkey      <= key;
                        r_round_cnt <= '0;
                        r_state     <= (mode ? w_ctr_base : in_data) ^ key;
                        if (mode) begin
                            r_counter <= w_ctr_next;
                        end else if (iv_load) begin
                            r_counter <= iv;
                        end
                        r_fsm <= S_RUN;
                    end else if (iv_load) begin
                        r_counter <= iv;
                    end
                end
                S_RUN: begin
                    // Extra cycle after the last round registers the output block.
                    if (r_round_cnt == CNT_W'(NR)) begin
                        r_out_data  <= r_state ^ (r_mode ? r_data : 128'd0);
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_state     <= w_st[ROUNDS_PER_CYCLE];
                        r_rkey      <= w_key[ROUNDS_PER_CYCLE];
                        r_round_cnt <= r_round_cnt + CNT_W'(ROUNDS_PER_CYCLE);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: four instances (1/2/5/10 rounds per cycle) checked
// every cycle against a behavioural AES/handshake model plus FIPS-197 vectors.
module tb_aes128_iter_core;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] key, in_data, iv;
    logic         mode, iv_load;
    logic         in_valid_a  [4];
    logic         out_ready_a [4];
    logic         in_ready_a  [4];
    logic         out_valid_a [4];
    logic         busy_a      [4];
    logic [127:0] out_data_a  [4];

    int total;
    int bad;
    int exp_lat [4] = '{11, 6, 3, 2};
    int rpc_tab [4] = '{1, 2, 5, 10};

    logic [7:0] tb_sbox [256];

    // Model state per instance: phase 0 idle, 1 busy, 2 holding a result.
    int           m_ph   [4];
    int           m_left [4];
    logic         m_rdy  [4];
    logic         m_ov   [4];
    logic [127:0] m_out  [4];
    logic [127:0] m_ctr  [4];

    logic [127:0] res, ivv, rnd, k1, p1, k2, p2;
    int           lat, rd, rh, n;
    bit           re;

    always #5 clk = ~clk;

    aes128_iter_core #(.ROUNDS_PER_CYCLE(1), .CTR_W(32)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .key(key), .in_data(in_data),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .mode(mode), .iv(iv),
        .iv_load(iv_load), .out_data(out_data_a[0]), .out_valid(out_valid_a[0]),
        .out_ready(out_ready_a[0]), .busy(busy_a[0]));
    aes128_iter_core #(.ROUNDS_PER_CYCLE(2), .CTR_W(32)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .key(key), .in_data(in_data),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .mode(mode), .iv(iv),
        .iv_load(iv_load), .out_data(out_data_a[1]), .out_valid(out_valid_a[1]),
        .out_ready(out_ready_a[1]), .busy(busy_a[1]));
    aes128_iter_core #(.ROUNDS_PER_CYCLE(5), .CTR_W(32)) u_dut5 (
        .wb_clk_i(clk), .wb_rst_i(rst), .key(key), .in_data(in_data),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .mode(mode), .iv(iv),
        .iv_load(iv_load), .out_data(out_data_a[2]), .out_valid(out_valid_a[2]),
        .out_ready(out_ready_a[2]), .busy(busy_a[2]));
    aes128_iter_core #(.ROUNDS_PER_CYCLE(10), .CTR_W(32)) u_dut10 (
        .wb_clk_i(clk), .wb_rst_i(rst), .key(key), .in_data(in_data),
        .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]), .mode(mode), .iv(iv),
        .iv_load(iv_load), .out_data(out_data_a[3]), .out_valid(out_valid_a[3]),
        .out_ready(out_ready_a[3]), .busy(busy_a[3]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_entry(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        if (x == 8'h00) b = 8'h00;
        else for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]],
                       tb_sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[c*4+q] = t[((c + q) % 4)*4 + q];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
                    s[c*4]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[c*4+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[c*4+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[c*4+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] ctr_inc(input logic [127:0] b);
        return {b[127:32], b[31:0] + 32'd1};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Cycle-level behavioural model of each instance.
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                m_ph[d] <= 0; m_left[d] <= 0; m_rdy[d] <= 1'b0; m_ov[d] <= 1'b0;
                m_out[d] <= '0; m_ctr[d] <= '0;
            end else if (m_ph[d] == 0) begin
                if (in_valid_a[d] && m_rdy[d]) begin
                    m_ph[d]   <= 1;
                    m_left[d] <= 1 + 10 / rpc_tab[d];
                    m_rdy[d]  <= 1'b0;
                    if (mode) begin
                        m_out[d] <= aes_enc(key, iv_load ? iv : m_ctr[d]) ^ in_data;
                        m_ctr[d] <= ctr_inc(iv_load ? iv : m_ctr[d]);
                    end else begin
                        m_out[d] <= aes_enc(key, in_data);
                        if (iv_load) m_ctr[d] <= iv;
                    end
                end else begin
                    m_rdy[d] <= 1'b1;
                    if (iv_load) m_ctr[d] <= iv;
                end
            end else if (m_ph[d] == 1) begin
                m_left[d] <= m_left[d] - 1;
                if (m_left[d] == 1) begin
                    m_ph[d] <= 2;
                    m_ov[d] <= 1'b1;
                end
            end else if (out_ready_a[d]) begin
                m_ph[d]  <= 0;
                m_ov[d]  <= 1'b0;
                m_rdy[d] <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("d%0d out_valid", d), 128'(out_valid_a[d]), 128'(m_ov[d]));
                chk($sformatf("d%0d busy", d), 128'(busy_a[d]), 128'(m_ph[d] == 1));
                chk($sformatf("d%0d in_ready", d), 128'(in_ready_a[d]), 128'(m_rdy[d]));
                if (rst) chk($sformatf("d%0d out_data reset", d), out_data_a[d], 128'd0);
                else if (m_ov[d]) chk($sformatf("d%0d out_data", d), out_data_a[d], m_out[d]);
            end
        end
    endtask

    // One block through instance d: accept, scramble inputs, wait, optional backpressure, handoff.
    task automatic do_block(input int d, input logic [127:0] k, input logic [127:0] din,
                            input logic md, input logic [127:0] ivin, input logic ivl,
                            input bit early, input int hold,
                            output logic [127:0] r, output int l);
        int w;
        key = k; in_data = din; mode = md; iv = ivin; iv_load = ivl;
        in_valid_a[d] = 1'b1;
        w = 0;
        while (!in_ready_a[d] && w < 50) begin
            @(posedge clk); #2; w++;
        end
        chk($sformatf("d%0d in_ready wait", d), 128'(in_ready_a[d]), 128'd1);
        @(posedge clk); #2;
        in_valid_a[d] = 1'b0; iv_load = 1'b0;
        key = rand128(); in_data = rand128(); iv = rand128(); mode = 1'($urandom_range(0, 1));
        out_ready_a[d] = early;
        l = 0;
        while (!out_valid_a[d] && l < 40) begin
            @(posedge clk); #2; l++;
        end
        chk($sformatf("d%0d out_valid wait", d), 128'(out_valid_a[d]), 128'd1);
        r = out_data_a[d];
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #2;
                chk($sformatf("d%0d hold valid", d), 128'(out_valid_a[d]), 128'd1);
                chk($sformatf("d%0d hold in_ready", d), 128'(in_ready_a[d]), 128'd0);
                chk($sformatf("d%0d hold data", d), out_data_a[d], r);
            end
            out_ready_a[d] = 1'b1;
        end
        @(posedge clk); #2;
        out_ready_a[d] = 1'b0;
        chk($sformatf("d%0d in_ready after handoff", d), 128'(in_ready_a[d]), 128'd1);
        chk($sformatf("d%0d out_valid after handoff", d), 128'(out_valid_a[d]), 128'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        key = '0; in_data = '0; iv = '0; mode = 1'b0; iv_load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_valid_a[d] = 1'b0; out_ready_a[d] = 1'b0;
        end
        for (int x = 0; x < 256; x++) tb_sbox[x] = sbox_entry(8'(x));
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        p1 = 128'h00112233445566778899aabbccddeeff;
        k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        p2 = 128'h3243f6a8885a308d313198a2e0370734;
        #1 rst = 1'b1;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        chk("model fips197", aes_enc(k1, p1), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("model appendix b", aes_enc(k2, p2), 128'h3925841d02dc09fbdc118597196a0b32);

        do_block(0, k1, p1, 1'b0, '0, 1'b0, 1'b0, 0, res, lat);
        chk("ecb fips rpc1", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("ecb fips rpc1 latency", 128'(lat), 128'd11);
        for (int d = 0; d < 4; d++) begin
            do_block(d, k2, p2, 1'b0, '0, 1'b0, 1'b0, 0, res, lat);
            chk($sformatf("ecb appb d%0d", d), res, 128'h3925841d02dc09fbdc118597196a0b32);
            chk($sformatf("ecb appb d%0d latency", d), 128'(lat), 128'(exp_lat[d]));
        end

        do_block(0, k1, p1, 1'b0, '0, 1'b0, 1'b0, 20, res, lat);
        chk("backpressure data", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        ivv = 128'h00112233445566778899aabbccddeeff;
        do_block(0, k1, '0, 1'b1, ivv, 1'b1, 1'b0, 0, res, lat);
        chk("ctr block1", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        do_block(0, k1, '0, 1'b1, '0, 1'b0, 1'b0, 0, res, lat);
        chk("ctr block2", res, aes_enc(k1, 128'h00112233445566778899aabbccddef00));
        do_block(0, k1, '0, 1'b1, '0, 1'b0, 1'b0, 0, res, lat);
        chk("ctr counter ccddef01", res, aes_enc(k1, 128'h00112233445566778899aabbccddef01));

        ivv = 128'h0123456789abcdef01234567ffffffff;
        rnd = rand128();
        do_block(1, k2, rnd, 1'b1, ivv, 1'b1, 1'b0, 0, res, lat);
        chk("ctr wrap block", res, aes_enc(k2, ivv) ^ rnd);
        do_block(1, k2, '0, 1'b1, '0, 1'b0, 1'b0, 0, res, lat);
        chk("ctr wrapped counter", res, aes_enc(k2, 128'h0123456789abcdef0123456700000000));

        key = k1; in_data = p1; mode = 1'b0; in_valid_a[0] = 1'b1;
        n = 0;
        while (!in_ready_a[0] && n < 50) begin
            @(posedge clk); #2; n++;
        end
        @(posedge clk); #2;
        in_valid_a[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset out_valid", 128'(out_valid_a[0]), 128'd0);
        chk("reset busy", 128'(busy_a[0]), 128'd0);
        chk("reset out_data", out_data_a[0], 128'd0);
        chk("reset in_ready", 128'(in_ready_a[0]), 128'd0);
        chk("reset out_data d1", out_data_a[1], 128'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        do_block(0, k1, p1, 1'b0, '0, 1'b0, 1'b0, 0, res, lat);
        chk("post reset ecb", res, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("post reset latency", 128'(lat), 128'd11);

        for (int i = 0; i < 60; i++) begin
            rd = $urandom_range(0, 3);
            re = ($urandom_range(0, 3) == 0);
            rh = $urandom_range(0, 3);
            do_block(rd, rand128(), rand128(), 1'($urandom_range(0, 1)), rand128(),
                     ($urandom_range(0, 3) == 0), re, rh, res, lat);
            chk($sformatf("random d%0d latency", rd), 128'(lat), 128'(exp_lat[rd]));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
